// File: rtl/vdp_vram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vdp_vram_slot_arbiter
// Brief    : VRAM access-slot scheduler. One slot per four clk21m cycles;
//            display/sprite fetch own fixed slots, CPU and command engine
//            share the free slots through a req/ack handshake.
// Options  : VDP_VRAM_ARB_RR_EN - round-robin between cpu and cmd in free
//            slots (default: fixed cpu-over-cmd priority).
// Revision : 1.0 - initial release
// ============================================================================
module vdp_vram_slot_arbiter (
    input  logic        reset,
    input  logic        clk21m,
    input  logic [1:0]  dotstate,
    input  logic [2:0]  eightdotstate,
    input  logic        window_x,
    input  logic        pre_window_y,
    input  logic        disp_en,
    input  logic        spr_en,
    input  logic [16:0] disp_addr,
    input  logic [16:0] spr_addr,
    output logic        disp_rdata_valid,
    output logic        spr_rdata_valid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [16:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        cmd_req,
    input  logic        cmd_we,
    input  logic [16:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        cmd_ack,
    output logic [7:0]  cmd_rdata,
    output logic [7:0]  fetch_rdata,
    output logic [16:0] vram_addr,
    output logic        vram_we,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    output logic [2:0]  owner
);

    localparam logic [2:0] c_OWN_IDLE = 3'd0;
    localparam logic [2:0] c_OWN_DISP = 3'd1;
    localparam logic [2:0] c_OWN_SPR  = 3'd2;
    localparam logic [2:0] c_OWN_CPU  = 3'd3;
    localparam logic [2:0] c_OWN_CMD  = 3'd4;

    // Slot phases: the decision edge starts a slot, the capture edge ends it.
    localparam logic [1:0] c_DOT_DECIDE  = 2'b10;
    localparam logic [1:0] c_DOT_CAPTURE = 2'b11;

    logic        w_active;
    logic        w_cpu_wins;
    logic [2:0]  w_next_owner;

    logic [2:0]  r_owner;
    logic [16:0] r_vram_addr;
    logic        r_vram_we;
    logic [7:0]  r_vram_wdata;
    logic [7:0]  r_cpu_rdata;
    logic [7:0]  r_cmd_rdata;
    logic [7:0]  r_fetch_rdata;
    logic        r_cpu_ack;
    logic        r_cmd_ack;
    logic        r_disp_valid;
    logic        r_spr_valid;

`ifdef VDP_VRAM_ARB_RR_EN
    logic r_last_cmd;

    // Cpu wins a contested slot only when cmd was the last one served.
    assign w_cpu_wins = r_last_cmd;

    // Remember which requester was served last, updated at every grant.
    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            r_last_cmd <= 1'b0;
        end else if (dotstate == c_DOT_DECIDE) begin
            if (w_next_owner == c_OWN_CPU) begin
                r_last_cmd <= 1'b0;
            end else if (w_next_owner == c_OWN_CMD) begin
                r_last_cmd <= 1'b1;
            end
        end
    end
`else
    assign w_cpu_wins = 1'b1;
`endif

    // Classify the slot and pick its owner; fixed fetch slots are never yielded.
    always_comb begin
        w_active     = window_x & pre_window_y;
        w_next_owner = c_OWN_IDLE;
        if (w_active && disp_en && (eightdotstate[2] == 1'b0)) begin
            w_next_owner = c_OWN_DISP;
        end else if (w_active && spr_en && (eightdotstate[2:1] == 2'b10)) begin
            w_next_owner = c_OWN_SPR;
        end else if (cpu_req && cmd_req) begin
            w_next_owner = w_cpu_wins ? c_OWN_CPU : c_OWN_CMD;
        end else if (cpu_req) begin
            w_next_owner = c_OWN_CPU;
        end else if (cmd_req) begin
            w_next_owner = c_OWN_CMD;
        end
    end

    // Slot datapath: latch the winner's request at the decision edge, capture
    // read data and pulse ack/valid at the capture edge.
    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            r_owner       <= c_OWN_IDLE;
            r_vram_addr   <= 17'd0;
            r_vram_we     <= 1'b0;
            r_vram_wdata  <= 8'd0;
            r_cpu_rdata   <= 8'd0;
            r_cmd_rdata   <= 8'd0;
            r_fetch_rdata <= 8'd0;
            r_cpu_ack     <= 1'b0;
            r_cmd_ack     <= 1'b0;
            r_disp_valid  <= 1'b0;
            r_spr_valid   <= 1'b0;
        end else begin
            r_cpu_ack    <= 1'b0;
            r_cmd_ack    <= 1'b0;
            r_disp_valid <= 1'b0;
            r_spr_valid  <= 1'b0;
            if (dotstate == c_DOT_DECIDE) begin
                r_owner <= w_next_owner;
                case (w_next_owner)
                    c_OWN_DISP: begin
                        r_vram_addr <= disp_addr;
                        r_vram_we   <= 1'b0;
                    end
                    c_OWN_SPR: begin
                        r_vram_addr <= spr_addr;
                        r_vram_we   <= 1'b0;
                    end
                    c_OWN_CPU: begin
                        r_vram_addr  <= cpu_addr;
                        r_vram_we    <= cpu_we;
                        r_vram_wdata <= cpu_wdata;
                    end
                    c_OWN_CMD: begin
                        r_vram_addr  <= cmd_addr;
                        r_vram_we    <= cmd_we;
                        r_vram_wdata <= cmd_wdata;
                    end
                    default: begin
                        r_vram_we <= 1'b0;
                    end
                endcase
            end else if (dotstate == c_DOT_CAPTURE) begin
                // r_vram_we still reflects this slot's direction here.
                r_vram_we <= 1'b0;
                case (r_owner)
                    c_OWN_DISP: begin
                        r_fetch_rdata <= vram_rdata;
                        r_disp_valid  <= 1'b1;
                    end
                    c_OWN_SPR: begin
                        r_fetch_rdata <= vram_rdata;
                        r_spr_valid   <= 1'b1;
                    end
                    c_OWN_CPU: begin
                        if (!r_vram_we) begin
                            r_cpu_rdata <= vram_rdata;
                        end
                        r_cpu_ack <= 1'b1;
                    end
                    c_OWN_CMD: begin
                        if (!r_vram_we) begin
                            r_cmd_rdata <= vram_rdata;
                        end
                        r_cmd_ack <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign owner            = r_owner;
    assign vram_addr        = r_vram_addr;
    assign vram_we          = r_vram_we;
    assign vram_wdata       = r_vram_wdata;
    assign cpu_rdata        = r_cpu_rdata;
    assign cmd_rdata        = r_cmd_rdata;
    assign fetch_rdata      = r_fetch_rdata;
    assign cpu_ack          = r_cpu_ack;
    assign cmd_ack          = r_cmd_ack;
    assign disp_rdata_valid = r_disp_valid;
    assign spr_rdata_valid  = r_spr_valid;

endmodule
`default_nettype wire

// File: tb/tb_vdp_vram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp_vram_slot_arbiter
// Brief    : Self-checking bench for vdp_vram_slot_arbiter. A slot-level
//            reference model predicts each slot's owner and VRAM outputs; a
//            scoreboard queue holds the expected ack/valid pulses, which a
//            separate monitor pops and checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdp_vram_slot_arbiter;

    localparam int c_PERIOD = 10;

    logic        clk21m = 1'b0;
    logic        reset;
    logic [1:0]  dotstate;
    logic [2:0]  eightdotstate;
    logic        window_x, pre_window_y, disp_en, spr_en;
    logic [16:0] disp_addr, spr_addr;
    logic        disp_rdata_valid, spr_rdata_valid;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cmd_req, cmd_we, cmd_ack;
    logic [16:0] cmd_addr;
    logic [7:0]  cmd_wdata, cmd_rdata;
    logic [7:0]  fetch_rdata;
    logic [16:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata, vram_rdata;
    logic [2:0]  owner;

    vdp_vram_slot_arbiter dut (
        .reset(reset), .clk21m(clk21m), .dotstate(dotstate), .eightdotstate(eightdotstate),
        .window_x(window_x), .pre_window_y(pre_window_y), .disp_en(disp_en), .spr_en(spr_en),
        .disp_addr(disp_addr), .spr_addr(spr_addr),
        .disp_rdata_valid(disp_rdata_valid), .spr_rdata_valid(spr_rdata_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata), .fetch_rdata(fetch_rdata),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata), .owner(owner)
    );

    always #(c_PERIOD / 2) clk21m = ~clk21m;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        time        t;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_ack[5] = '{0, 0, 0, 0, 0};

    // reference model state (slot level)
    logic [2:0]  m_owner, m_nxt;
    logic [16:0] m_addr;
    logic        m_we;
    logic [7:0]  m_wdata, m_cpu_rd, m_cmd_rd, m_fetch_rd;
    logic        m_last_cmd;

    // stimulus configuration
    int ph = 0;
    int g_slot = 0;
    int g_act_mode = 0;   // 0 inactive, 1 active, 2 random (also mid-slot)
    int g_en_mode = 2;    // 0 random, 1 both on, 2 both off
    int g_req_pct = 0;
    int g_rd = -1;        // forced vram_rdata, or -1 for random

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] dseq(input int idx);
        case (idx)
            0: return 2'b00;
            1: return 2'b01;
            2: return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // Owner of a slot, straight from the slot classification rules.
    function automatic logic [2:0] model_owner();
        logic act;
        act = window_x & pre_window_y;
        if (act && disp_en && eightdotstate <= 3'd3) return 3'd1;
        if (act && spr_en && (eightdotstate == 3'd4 || eightdotstate == 3'd5)) return 3'd2;
        if (cpu_req && cmd_req) begin
`ifdef VDP_VRAM_ARB_RR_EN
            return m_last_cmd ? 3'd3 : 3'd4;
`else
            return 3'd3;
`endif
        end
        if (cpu_req) return 3'd3;
        if (cmd_req) return 3'd4;
        return 3'd0;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_addr = 0; m_we = 0; m_wdata = 0;
        m_cpu_rd = 0; m_cmd_rd = 0; m_fetch_rd = 0; m_last_cmd = 0;
    endtask

    task automatic randomize_flags();
        case (g_act_mode)
            0: begin window_x = 1'b0; pre_window_y = 1'($urandom); end
            1: begin window_x = 1'b1; pre_window_y = 1'b1; end
            default: begin window_x = 1'($urandom); pre_window_y = 1'($urandom); end
        endcase
        case (g_en_mode)
            0: begin disp_en = 1'($urandom); spr_en = 1'($urandom); end
            1: begin disp_en = 1'b1; spr_en = 1'b1; end
            default: begin disp_en = 1'b0; spr_en = 1'b0; end
        endcase
    endtask

    task automatic prep_decision();
        eightdotstate = 3'(g_slot);
        g_slot++;
        randomize_flags();
        disp_addr  = 17'($urandom);
        spr_addr   = 17'($urandom);
        vram_rdata = (g_rd < 0) ? 8'($urandom) : 8'(g_rd);
        if (!cpu_req && $urandom_range(0, 99) < g_req_pct) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom);
            cpu_addr = 17'($urandom); cpu_wdata = 8'($urandom);
        end
        if (!cmd_req && $urandom_range(0, 99) < g_req_pct) begin
            cmd_req = 1'b1; cmd_we = 1'($urandom);
            cmd_addr = 17'($urandom); cmd_wdata = 8'($urandom);
        end
        m_nxt = model_owner();
    endtask

    task automatic apply_decision();
        exp_t e;
        m_owner = m_nxt;
        case (m_nxt)
            3'd1: begin m_addr = disp_addr; m_we = 1'b0; end
            3'd2: begin m_addr = spr_addr;  m_we = 1'b0; end
            3'd3: begin m_addr = cpu_addr; m_we = cpu_we; m_wdata = cpu_wdata; m_last_cmd = 1'b0; end
            3'd4: begin m_addr = cmd_addr; m_we = cmd_we; m_wdata = cmd_wdata; m_last_cmd = 1'b1; end
            default: m_we = 1'b0;
        endcase
        if (m_nxt != 3'd0) begin
            e.kind = m_nxt;
            e.t    = $time - 1 + 3 * c_PERIOD;
            case (m_nxt)
                3'd3:    e.data = m_we ? m_cpu_rd : vram_rdata;
                3'd4:    e.data = m_we ? m_cmd_rd : vram_rdata;
                default: e.data = vram_rdata;
            endcase
            sb.push_back(e);
        end
    endtask

    task automatic apply_capture();
        case (m_owner)
            3'd1, 3'd2: m_fetch_rd = vram_rdata;
            3'd3: if (!m_we) m_cpu_rd = vram_rdata;
            3'd4: if (!m_we) m_cmd_rd = vram_rdata;
            default: ;
        endcase
        m_we = 1'b0;
    endtask

    task automatic compare_all();
        chk("owner", 32'(owner), 32'(m_owner));
        chk("vram_addr", 32'(vram_addr), 32'(m_addr));
        chk("vram_we", 32'(vram_we), 32'(m_we));
        chk("vram_wdata", 32'(vram_wdata), 32'(m_wdata));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
        chk("cmd_rdata", 32'(cmd_rdata), 32'(m_cmd_rd));
        chk("fetch_rdata", 32'(fetch_rdata), 32'(m_fetch_rd));
    endtask

    task automatic one_edge();
        logic [1:0] ds;
        ds = dseq(ph);
        dotstate = ds;
        if (ds == 2'b10) prep_decision();
        else if (g_act_mode == 2) randomize_flags();
        @(posedge clk21m);
        #1;
        if (!reset) begin
            if (ds == 2'b10) apply_decision();
            else if (ds == 2'b11) apply_capture();
        end
        compare_all();
        if (cpu_ack) cpu_req = 1'b0;
        if (cmd_ack) cmd_req = 1'b0;
        ph = (ph + 1) % 4;
    endtask

    // Monitor: every ack/valid pulse must match the oldest expected pulse.
    initial begin : monitor
        int   n_hi;
        exp_t e;
        logic [2:0] kind;
        logic [7:0] data;
        forever begin
            @(posedge clk21m);
            #1;
            n_hi = int'(cpu_ack) + int'(cmd_ack) + int'(disp_rdata_valid) + int'(spr_rdata_valid);
            chk("single_pulse", 32'(n_hi > 1), 32'd0);
            if (n_hi == 1) begin
                if (cpu_ack)               begin kind = 3'd3; data = cpu_rdata;   end
                else if (cmd_ack)          begin kind = 3'd4; data = cmd_rdata;   end
                else if (disp_rdata_valid) begin kind = 3'd1; data = fetch_rdata; end
                else                       begin kind = 3'd2; data = fetch_rdata; end
                n_ack[kind]++;
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'(kind), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", 32'(kind), 32'(e.kind));
                    chk("pulse_data", 32'(data), 32'(e.data));
                    chk("pulse_time", 32'($time - 1), 32'(e.t));
                end
            end
            while (sb.size() > 0 && sb[0].t < $time - 1) begin
                e = sb.pop_front();
                chk("missing_pulse", 32'd0, 32'(e.kind));
            end
        end
    end

    initial begin : stimulus
        int a_cpu, a_cmd, a_disp, a_spr;
        logic [7:0] snap;
        reset = 1'b1;
        dotstate = 2'b00; eightdotstate = 3'd0;
        window_x = 0; pre_window_y = 0; disp_en = 0; spr_en = 0;
        disp_addr = 0; spr_addr = 0; vram_rdata = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        cmd_req = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0;
        model_reset();

        // reset state
        repeat (3) one_edge();
        chk("rst_disp_valid", 32'(disp_rdata_valid), 32'd0);
        chk("rst_spr_valid", 32'(spr_rdata_valid), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_cmd_ack", 32'(cmd_ack), 32'd0);
        reset = 1'b0;

        // single cpu read in a free slot
        g_rd = 8'hA5;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h12345;
        one_edge();
        chk("t1_owner", 32'(owner), 32'd3);
        chk("t1_addr", 32'(vram_addr), 32'h12345);
        repeat (3) one_edge();
        chk("t1_ack", 32'(cpu_ack), 32'd1);
        chk("t1_rdata", 32'(cpu_rdata), 32'hA5);
        g_rd = -1;

        // display + sprite slots hold off a waiting cpu read until slot 6
        g_slot = 0; g_act_mode = 1; g_en_mode = 1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00ABC;
        a_cpu = n_ack[3]; a_disp = n_ack[1]; a_spr = n_ack[2];
        repeat (24) one_edge();
        chk("t2_disp_cnt", 32'(n_ack[1] - a_disp), 32'd4);
        chk("t2_spr_cnt", 32'(n_ack[2] - a_spr), 32'd2);
        chk("t2_cpu_early", 32'(n_ack[3] - a_cpu), 32'd0);
        repeat (4) one_edge();
        chk("t2_cpu_slot6", 32'(n_ack[3] - a_cpu), 32'd1);

        // reset in the middle of a cpu write slot
        g_act_mode = 0; g_en_mode = 2;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h1F0F0; cpu_wdata = 8'h3C;
        one_edge();
        chk("t3_owner_pre", 32'(owner), 32'd3);
        chk("t3_we_pre", 32'(vram_we), 32'd1);
        dotstate = 2'b00;
        reset = 1'b1;
        #1;
        chk("t3_we_rst", 32'(vram_we), 32'd0);
        chk("t3_owner_rst", 32'(owner), 32'd0);
        chk("t3_ack_rst", 32'(cpu_ack), 32'd0);
        if (sb.size() > 0) void'(sb.pop_back());
        model_reset();
        a_cpu = n_ack[3];
        repeat (2) one_edge();
        reset = 1'b0;
        one_edge();
        chk("t3_no_ack", 32'(cpu_ack), 32'd0);
        repeat (4) one_edge();
        chk("t3_served", 32'(n_ack[3] - a_cpu), 32'd1);

        // cpu and cmd both requesting in free slots
        g_req_pct = 100;
        a_cpu = n_ack[3]; a_cmd = n_ack[4];
        repeat (16) one_edge();
`ifdef VDP_VRAM_ARB_RR_EN
        chk("t4_cpu_cnt", 32'(n_ack[3] - a_cpu), 32'd2);
        chk("t4_cmd_cnt", 32'(n_ack[4] - a_cmd), 32'd2);
`else
        chk("t4_cpu_cnt", 32'(n_ack[3] - a_cpu), 32'd4);
        chk("t4_cmd_cnt", 32'(n_ack[4] - a_cmd), 32'd0);
`endif
        g_req_pct = 0;
        cpu_req = 1'b0; cmd_req = 1'b0;

        // cmd write: vram_we high for exactly three cycles, cmd_rdata held
        snap = m_cmd_rd;
        cmd_req = 1'b1; cmd_we = 1'b1; cmd_wdata = 8'h5A; cmd_addr = 17'h00010;
        one_edge();
        chk("t5_owner", 32'(owner), 32'd4);
        chk("t5_we0", 32'(vram_we), 32'd1);
        chk("t5_wdata", 32'(vram_wdata), 32'h5A);
        chk("t5_addr", 32'(vram_addr), 32'h10);
        one_edge();
        chk("t5_we1", 32'(vram_we), 32'd1);
        one_edge();
        chk("t5_we2", 32'(vram_we), 32'd1);
        one_edge();
        chk("t5_we3", 32'(vram_we), 32'd0);
        chk("t5_ack", 32'(cmd_ack), 32'd1);
        chk("t5_rdata_hold", 32'(cmd_rdata), 32'(snap));

        // randomized traffic with changing window flags and enables
        g_act_mode = 2; g_en_mode = 0; g_req_pct = 35;
        repeat (1200) one_edge();

        // drain outstanding requests
        g_act_mode = 0; g_en_mode = 2; g_req_pct = 0;
        repeat (40) one_edge();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vdp_vram_slot_arbiter.md
# vdp_vram_slot_arbiter

VRAM access-slot scheduler for the VDP. Sits between the sync signal generator (which supplies `dotstate`, `eightdotstate` and the display window flags) and the single VRAM port. Divides VRAM bandwidth into one access slot per four `clk21m` cycles. Display and sprite fetch own fixed slots; the CPU port and the command engine compete for the remaining free slots through a req/ack handshake.

## Interface
- No parameters.
- `reset` in 1: asynchronous, active-high.
- `clk21m` in 1: single clock, 21.48 MHz.
- `dotstate` in 2: from SSG; sequence 00→01→11→10 repeating.
- `eightdotstate` in 3: from SSG; slot index 0-7 within an 8-dot group.
- `window_x`, `pre_window_y` in 1 each: active display window flags.
- `disp_en`, `spr_en` in 1 each: enable display fetch and sprite fetch.
- `disp_addr`, `spr_addr` in 17 each: fetch addresses.
- `disp_rdata_valid`, `spr_rdata_valid` out 1 each: one-cycle pulse when the fetch data is valid.
- `cpu_req`, `cpu_we` in 1 each; `cpu_addr` in 17; `cpu_wdata` in 8.
- `cpu_ack` out 1; `cpu_rdata` out 8.
- `cmd_req`, `cmd_we` in 1 each; `cmd_addr` in 17; `cmd_wdata` in 8.
- `cmd_ack` out 1; `cmd_rdata` out 8.
- `fetch_rdata` out 8: captured data for display and sprite.
- `vram_addr` out 17; `vram_we` out 1; `vram_wdata` out 8; `vram_rdata` in 8.
- `owner` out 3: current slot owner. 0 = idle, 1 = disp, 2 = spr, 3 = cpu, 4 = cmd.

## Operation
- Decision edge: the rising edge of `clk21m` where `dotstate`==10. Owner is chosen from the values sampled at that edge.
- `active` = `window_x` & `pre_window_y`.
- Slot classification:
  - `active` & `disp_en` & `eightdotstate` in 0-3 → disp.
  - `active` & `spr_en` & `eightdotstate` in 4-5 → spr.
  - All other slots are free.
- Free slot, only one of `cpu_req`/`cmd_req` high → that requester owns the slot.
- Free slot, both high → cpu wins (fixed priority; see Configuration).
- Free slot, neither high → idle.
- Fixed slots are never yielded. A CPU or command request waits through them.
- Owned slot: `vram_addr`, `vram_we` and `vram_wdata` are taken from the owner's inputs and held for the whole slot.
- Idle slot: `vram_we`=0, `vram_addr` holds its previous value.
- Pending flags: a cpu or cmd access, once granted, completes and is acknowledged even if the request drops mid-slot.
- Handshake rule: a requester holds `req`, `we`, `addr` and `wdata` stable until it sees `ack`.
- A requester that still holds `req` in the cycle after `ack` is treated as a new request.

## Timing
- Edge at `dotstate`==10 (decision): `owner` and the VRAM outputs update. `vram_we`=1 for a write.
- Edge at `dotstate`==00: outputs unchanged.
- Edge at `dotstate`==01: outputs unchanged.
- Edge at `dotstate`==11:
  - `vram_rdata` is captured into `cpu_rdata`, `cmd_rdata` or `fetch_rdata` according to `owner`.
  - `vram_we` goes to 0.
  - The matching `*_ack` or `*_rdata_valid` pulses high for exactly the one following cycle.
- Latency, request asserted at a decision edge with a free slot: ack high 3 cycles after that edge.
- Worst case, cpu: 6 display/sprite slots plus 1 lost arbitration = 7 slots (28 cycles).
- Only the rdata of the current owner is updated. Rdata of other requesters holds.
- Write slots also pulse ack. `cpu_rdata` and `cmd_rdata` are not updated on writes.
- `reset` asserted at any time, including mid-slot: all outputs return to reset values immediately and pending grants are discarded.
  - Reset values: `owner`=0, `vram_addr`=0, `vram_we`=0, `vram_wdata`=0, all rdata=0, all ack/valid=0.
- `active` changing mid-slot does not affect the slot already decided.

## Configuration
- `VDP_VRAM_ARB_RR_EN` defined: round-robin between cpu and cmd in free slots.
  - A 1-bit `last_cmd` register is set when cmd is served and cleared when cpu is served; reset value 0.
  - Both requesting: cmd wins if `last_cmd`=0, otherwise cpu wins.
  - Single requester: that requester is served, and `last_cmd` still updates.
- `VDP_VRAM_ARB_RR_EN` undefined: fixed cpu-over-cmd priority and no `last_cmd` register.

## Test plan
- Reset, `active`=0, `cpu_req`=1, `cpu_we`=0, `cpu_addr`=0x1_2345, `vram_rdata`=0xA5 → `owner`=3 and `vram_addr`=0x12345 at the first decision edge; `cpu_ack` pulses 3 cycles later with `cpu_rdata`=0xA5.
- `active`=1, `disp_en`=1, `eightdotstate`=0, `cpu_req` held → slots 0-3 have `owner`=1 with `disp_rdata_valid` pulsing 4 times; `cpu_ack` does not occur before slot 6.
- Both `cpu_req` and `cmd_req` held, `active`=0:
  - Macro undefined → 4 consecutive cpu acks, 0 cmd acks.
  - Macro defined → acks alternate cmd, cpu, cmd, cpu.
- `cmd_we`=1, `cmd_wdata`=0x5A, `cmd_addr`=0x00010 → `vram_we` high for exactly 3 cycles (from the decision edge to the `dotstate`==11 edge) with `vram_wdata`=0x5A; `cmd_ack` pulses once; `cmd_rdata` is unchanged.
- `reset` asserted at `dotstate`==00 during a cpu write slot → `vram_we`=0, `owner`=0 and `cpu_ack`=0 immediately; no ack after release until a new decision edge serves the request.
